ysyx_22040125_data_mem: RTL and testbench

Parametrised data memory for the ysyx_22040125 RV64 core's load/store path; successor to the single-cycle data RAM. Adds a valid/ready request interface, per-byte write strobes, configurable depth and data width, a fixed-latency pipelined read response, range checking, and a post-reset zero-initialisation sweep. Sits between the LSU and the simulation memory model; one request accepted per cycle once initialised.

---
 rtl/ysyx_22040125_mem_pkg.sv | 24 ++
 rtl/ysyx_22040125_mem_pipe.sv | 39 +++
 rtl/ysyx_22040125_data_mem.sv | 145 ++++++++++++++
 tb/tb_ysyx_22040125_data_mem.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040125_mem_pkg.sv
// Shared types and helpers for the ysyx_22040125 data memory.
//   state_e     : INIT (post-reset zero sweep) / RUN (serving requests)
//   lane_count  : number of byte lanes in a data word
//   rsp_s       : response payload at the core's native 64-bit width
package ysyx_22040125_mem_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic {
        STATE_INIT = 1'b0,
        STATE_RUN  = 1'b1
    } state_e;

    function automatic int unsigned lane_count(input int unsigned data_w);
        return data_w / 8;
    endfunction

    typedef struct packed {
        logic            valid;
        logic            err;
        logic [XLEN-1:0] rdata;
    } rsp_s;

endpackage

// File: rtl/ysyx_22040125_mem_pipe.sv
// Fixed-latency response pipeline: LATENCY-deep shift register with
// synchronous clear. LATENCY=1 degenerates to a single register.
//   clk, rst : clock, synchronous active-high clear of all stages
//   in_rsp   : response entering the pipe (registered at this edge)
//   out_rsp  : response leaving the last stage
module ysyx_22040125_mem_pipe #(
    parameter int unsigned WIDTH   = 66,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_rsp,
    output logic [WIDTH-1:0] out_rsp
);

    logic [WIDTH-1:0] stage_q [LATENCY];
    logic [WIDTH-1:0] stage_d [LATENCY];

    // Each stage takes the previous one; stage 0 takes the new response.
    always_comb begin
        stage_d[0] = in_rsp;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < LATENCY; i++) begin
            if (rst) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_rsp = stage_q[LATENCY-1];

endmodule

// File: rtl/ysyx_22040125_data_mem.sv
// Data memory for the LSU: valid/ready requests, byte-strobed stores,
// range checking, fixed-latency in-order responses and an optional
// post-reset zero sweep.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : request handshake (ready only in RUN)
//   req_wen           : 1 = store, 0 = load
//   req_addr          : byte address, low lane bits ignored
//   req_wdata/wstrb   : store data and per-byte enables
//   rsp_valid         : one-cycle pulse per accepted request
//   rsp_rdata/rsp_err : load data / out-of-range flag, zero when idle
module ysyx_22040125_data_mem
    import ysyx_22040125_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wen,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [lane_count(DATA_W)-1:0] req_wstrb,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err
);

    localparam int unsigned LANES  = lane_count(DATA_W);
    localparam int unsigned OFF_W  = $clog2(LANES);
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RSP_W  = DATA_W + 2;

    // Same layout as rsp_s, sized to this instance's word width.
    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    state_e              state_q, state_d;
    logic [MEM_AW-1:0]   cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [ADDR_W-1:0]   word_idx;
    logic [MEM_AW-1:0]   mem_idx;
    logic                in_range;
    logic                accept;
    logic                init_wr;
    logic                store_wr;
    rsp_t                rsp_in;
    rsp_t                rsp_out;
    logic                unused_addr;

    assign word_idx    = req_addr >> OFF_W;
    assign mem_idx     = word_idx[MEM_AW-1:0];
    assign in_range    = word_idx < ADDR_W'(DEPTH);
    assign unused_addr = ^req_addr;

    // A request coinciding with a reset edge is discarded.
    assign accept   = req_valid & ready_q & ~rst;
    assign init_wr  = (state_q == STATE_INIT) & ~rst;
    assign store_wr = accept & req_wen & in_range;

    // Next-state: sweep every word once, then serve requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // Ready follows the state one cycle later so the RUN state is
        // fully established before the first accept.
        ready_d = (state_q == STATE_RUN);
        case (state_q)
            STATE_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == MEM_AW'(DEPTH - 1)) begin
                    state_d = STATE_RUN;
                    cnt_d   = '0;
                end
            end
            STATE_RUN: begin
            end
            default: begin
                state_d = STATE_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_ZERO != 0) ? STATE_INIT : STATE_RUN;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Storage: zero sweep during INIT, byte-lane writes in RUN.
    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem_q[cnt_q] <= '0;
        end else if (store_wr) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (req_wstrb[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response captured at the accept edge; loads see all earlier stores.
    always_comb begin
        rsp_in = '0;
        if (accept) begin
            rsp_in.valid = 1'b1;
            rsp_in.err   = ~in_range;
            if (!req_wen && in_range) begin
                rsp_in.rdata = mem_q[mem_idx];
            end
        end
    end

    ysyx_22040125_mem_pipe #(
        .WIDTH   (RSP_W),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_rsp  (rsp_in),
        .out_rsp (rsp_out)
    );

    assign req_ready = ready_q;
    assign rsp_valid = rsp_out.valid;
    assign rsp_err   = rsp_out.err;
    assign rsp_rdata = rsp_out.rdata;

endmodule

// File: tb/tb_ysyx_22040125_data_mem.sv
// Directed bench for ysyx_22040125_data_mem. Four instances share one
// stimulus stream: LATENCY 1/2/3 with the zero sweep, and LATENCY 1
// without it. A 16-word reference array predicts every response.
module tb_ysyx_22040125_data_mem;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;

    logic        l1_ready, l2_ready, l3_ready, nz_ready;
    logic        l1_valid, l2_valid, l3_valid, nz_valid;
    logic [63:0] l1_rdata, l2_rdata, l3_rdata, nz_rdata;
    logic        l1_err, l2_err, l3_err, nz_err;

    logic [63:0] ref_mem [16];
    int          n_chk;
    int          n_bad;
    int          first;
    int          nz_first;

    ysyx_22040125_data_mem #(.DEPTH(16), .LATENCY(1), .INIT_ZERO(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(l1_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(l1_valid), .rsp_rdata(l1_rdata),
        .rsp_err(l1_err));

    ysyx_22040125_data_mem #(.DEPTH(16), .LATENCY(2), .INIT_ZERO(1)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(l2_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(l2_valid), .rsp_rdata(l2_rdata),
        .rsp_err(l2_err));

    ysyx_22040125_data_mem #(.DEPTH(16), .LATENCY(3), .INIT_ZERO(1)) u_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(l3_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(l3_valid), .rsp_rdata(l3_rdata),
        .rsp_err(l3_err));

    ysyx_22040125_data_mem #(.DEPTH(16), .LATENCY(1), .INIT_ZERO(0)) u_nz (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(nz_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(nz_valid), .rsp_rdata(nz_rdata),
        .rsp_err(nz_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on the LATENCY=1 instance; response checked after the
    // accept edge against the reference array.
    task automatic op(input logic wen, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [7:0] ws);
        logic [63:0] exp_d;
        logic        exp_e;
        int          idx;
        idx   = int'(addr >> 3);
        exp_e = (idx >= 16);
        exp_d = '0;
        if (!exp_e) begin
            if (wen) begin
                for (int b = 0; b < 8; b++) begin
                    if (ws[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                exp_d = ref_mem[idx];
            end
        end
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        check("req_ready", 64'(l1_ready), 64'd1);
        @(posedge clk); #1;
        check("rsp_valid", 64'(l1_valid), 64'd1);
        check("rsp_rdata", l1_rdata, exp_d);
        check("rsp_err", 64'(l1_err), 64'(exp_e));
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
        check("idle_valid", 64'(l1_valid), 64'd0);
        check("idle_rdata", l1_rdata, 64'd0);
    endtask

    // Counts edges after reset release until ready; edge 0 is the first
    // edge with rst low.
    task automatic wait_ready;
        first    = -1;
        nz_first = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (nz_ready && nz_first < 0) nz_first = i;
            if (l1_ready && first < 0) first = i;
        end
    endtask

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        // Reset state while rst is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_l1", 64'(l1_ready), 64'd0);
        check("rst_ready_nz", 64'(nz_ready), 64'd0);
        check("rst_valid_l3", 64'(l3_valid), 64'd0);
        check("rst_rdata_l1", l1_rdata, 64'd0);
        check("rst_err_l1", 64'(l1_err), 64'd0);

        // Sweep of 16 words, versus immediate readiness without it.
        rst = 1'b0;
        wait_ready();
        check("init_ready_edge", 64'(first), 64'd16);
        check("nz_ready_edge", 64'(nz_first), 64'd0);

        // Every word cleared by the sweep.
        for (int i = 0; i < 16; i++) op(1'b0, 32'(i * 8), '0, '0);
        idle(1);

        // Full store then single-lane merge.
        op(1'b1, 32'h8, 64'h1122334455667788, 8'hFF);
        op(1'b1, 32'h8, 64'h000000000000AA00, 8'h02);
        op(1'b0, 32'h8, '0, '0);
        check("merge_value", l1_rdata, 64'h112233445566AA88);
        // Zero strobe is acknowledged but writes nothing; low bits ignored.
        op(1'b1, 32'h8, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        op(1'b0, 32'hD, '0, '0);
        check("strobe0_value", l1_rdata, 64'h112233445566AA88);

        // Out-of-range index 16.
        op(1'b0, 32'h80, '0, '0);
        check("oor_err", 64'(l1_err), 64'd1);
        check("oor_rdata", l1_rdata, 64'd0);
        op(1'b1, 32'h80, 64'hDEADBEEFDEADBEEF, 8'hFF);
        for (int i = 0; i < 16; i++) op(1'b0, 32'(i * 8), '0, '0);
        idle(4);

        // LATENCY=3: store then load back-to-back at 0x10.
        op(1'b1, 32'h10, 64'h0123456789ABCDEF, 8'hFF);
        check("l3_s_e1", 64'(l3_valid), 64'd0);
        op(1'b0, 32'h10, '0, '0);
        check("l3_l_e1", 64'(l3_valid), 64'd0);
        @(posedge clk); #1;
        check("l3_store_valid", 64'(l3_valid), 64'd1);
        check("l3_store_rdata", l3_rdata, 64'd0);
        @(posedge clk); #1;
        check("l3_load_valid", 64'(l3_valid), 64'd1);
        check("l3_load_rdata", l3_rdata, 64'h0123456789ABCDEF);
        @(posedge clk); #1;
        check("l3_after_valid", 64'(l3_valid), 64'd0);
        check("l3_after_rdata", l3_rdata, 64'd0);
        idle(2);

        // Back-to-back random stream, including out-of-range indices.
        for (int i = 0; i < 100; i++) begin
            op(1'($urandom_range(0, 1)), 32'($urandom_range(0, 'h9F)),
               {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        end
        idle(4);

        // Reset with loads in flight: nothing may emerge afterwards.
        op(1'b0, 32'h8, '0, '0);
        op(1'b0, 32'h10, '0, '0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("flush_valid_l2", 64'(l2_valid), 64'd0);
            check("flush_valid_l3", 64'(l3_valid), 64'd0);
            check("flush_ready", 64'(l1_ready), 64'd0);
        end
        rst = 1'b0;
        wait_ready();
        check("reinit_ready_edge", 64'(first), 64'd16);
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        op(1'b0, 32'h8, '0, '0);
        check("reinit_cleared", l1_rdata, 64'd0);
        op(1'b0, 32'h10, '0, '0);
        idle(1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
